// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO using all DEPTH entries, with occupancy count,
// programmable almost-full/empty thresholds, optional FWFT read and sticky error flags.
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    parameter bit          FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     data_1_en,
    input  logic [DATA_W-1:0]        data_1,
    input  logic                     data_2_rd,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        data_2,
    output logic                     data_2_valid,
    output logic                     buffer_empty,
    output logic                     buffer_full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [LvlW-1:0]   level_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_acc;
    logic              rd_acc;

    // Status flags decode the registered level only, so acceptance never sees a same-cycle op.
    assign buffer_empty = (level_q == '0);
    assign buffer_full  = (level_q == LvlW'(DEPTH));
    assign almost_full  = (level_q >= LvlW'(AF_THRESH));
    assign almost_empty = (level_q <= LvlW'(AE_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = data_1_en && !buffer_full;
    assign rd_acc = data_2_rd && !buffer_empty;

    // Storage is deliberately not reset; requests during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= data_1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (wr_acc && !rd_acc) begin
                level_q <= level_q + LvlW'(1);
            end else if (rd_acc && !wr_acc) begin
                level_q <= level_q - LvlW'(1);
            end
        end
    end

    // Set has priority over clear so an error coinciding with err_clr is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (data_1_en && buffer_full) || (overflow_q && !err_clr);
            underflow_q <= (data_2_rd && buffer_empty) || (underflow_q && !err_clr);
        end
    end

    if (FWFT) begin : g_fwft
        assign data_2       = mem[rd_ptr_q];
        assign data_2_valid = !buffer_empty;
    end else begin : g_reg
        logic [DATA_W-1:0] data_2_q;
        logic              valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_2_q <= '0;
                valid_q  <= 1'b0;
            end else begin
                valid_q <= rd_acc;
                if (rd_acc) begin
                    data_2_q <= mem[rd_ptr_q];
                end
            end
        end

        assign data_2       = data_2_q;
        assign data_2_valid = valid_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench: one registered-read and one FWFT instance share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = DEPTH - 2;
    localparam int unsigned AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          data_1_en;
    logic [DW-1:0] data_1;
    logic          data_2_rd;
    logic          err_clr;

    logic [DW-1:0] r_data, f_data;
    logic          r_valid, f_valid;
    logic          r_empty, f_empty, r_full, f_full;
    logic          r_af, f_af, r_ae, f_ae;
    logic [3:0]    r_level, f_level;
    logic          r_ovf, f_ovf, r_udf, f_udf;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state
    logic [DW-1:0] model[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;
    logic [DW-1:0] exp0_data[$];
    int            exp0_due[$];
    logic [DW-1:0] exp1_data[$];
    int            popped = 0;

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b0)) u_reg (
        .clk(clk), .rst(rst), .data_1_en(data_1_en), .data_1(data_1), .data_2_rd(data_2_rd),
        .err_clr(err_clr), .data_2(r_data), .data_2_valid(r_valid), .buffer_empty(r_empty),
        .buffer_full(r_full), .almost_full(r_af), .almost_empty(r_ae), .level(r_level),
        .overflow(r_ovf), .underflow(r_udf)
    );

    sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(rst), .data_1_en(data_1_en), .data_1(data_1), .data_2_rd(data_2_rd),
        .err_clr(err_clr), .data_2(f_data), .data_2_valid(f_valid), .buffer_empty(f_empty),
        .buffer_full(f_full), .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Registered-read monitor: each accepted read must yield exactly one valid pulse next cycle.
    always @(negedge clk) begin
        if (r_valid) begin
            if (exp0_data.size() == 0) begin
                check("reg_unexpected_valid", 32'(r_valid), 32'd0);
            end else begin
                check("reg_data", 32'(r_data), 32'(exp0_data.pop_front()));
                check("reg_latency", 32'(cyc), 32'(exp0_due.pop_front()));
            end
        end else if (exp0_due.size() != 0 && exp0_due[0] <= cyc) begin
            check("reg_missing_valid", 32'(r_valid), 32'd1);
            void'(exp0_data.pop_front());
            void'(exp0_due.pop_front());
        end
    end

    // FWFT monitor: a pop with valid high consumes the word currently shown.
    always @(negedge clk) begin
        if (!rst && data_2_rd && f_valid) begin
            if (exp1_data.size() == 0) begin
                check("fwft_unexpected_pop", 32'(f_valid), 32'd0);
            end else begin
                check("fwft_data", 32'(f_data), 32'(exp1_data.pop_front()));
            end
        end
    end

    task automatic check_status();
        int lvl;
        lvl = model.size();
        check("level", 32'(r_level), 32'(lvl));
        check("fwft_level", 32'(f_level), 32'(lvl));
        check("empty", 32'(r_empty), 32'(lvl == 0));
        check("full", 32'(r_full), 32'(lvl == DEPTH));
        check("almost_full", 32'(r_af), 32'(lvl >= AF));
        check("almost_empty", 32'(r_ae), 32'(lvl <= AE));
        check("fwft_flags", 32'({f_empty, f_full, f_af, f_ae}),
              32'({lvl == 0, lvl == DEPTH, lvl >= AF, lvl <= AE}));
        check("overflow", 32'({r_ovf, f_ovf}), 32'({m_ovf, m_ovf}));
        check("underflow", 32'({r_udf, f_udf}), 32'({m_udf, m_udf}));
        check("fwft_valid", 32'(f_valid), 32'(lvl != 0));
        if (lvl != 0) check("fwft_head", 32'(f_data), 32'(model[0]));
    endtask

    // Apply one cycle of inputs, advance the model, then check status after the edge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic clr, input logic rs);
        logic full, empty;
        logic [DW-1:0] head;
        data_1_en = we;
        data_1    = wd;
        data_2_rd = re;
        err_clr   = clr;
        rst       = rs;
        if (rs) begin
            model.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            full  = (model.size() == DEPTH);
            empty = (model.size() == 0);
            if (re && !empty) begin
                head = model.pop_front();
                exp0_data.push_back(head);
                exp0_due.push_back(cyc + 1);
                exp1_data.push_back(head);
                popped++;
            end
            if (we && !full) model.push_back(wd);
            m_ovf = (we && full) || (m_ovf && !clr);
            m_udf = (re && empty) || (m_udf && !clr);
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    initial begin
        logic we, re;
        // Reset with a write request held high
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        check("rst_data_2", 32'(r_data), 32'd0);
        check("rst_valid", 32'(r_valid), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Fill, then overflow
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        check("ovf_after_fill", 32'({r_ovf, r_level}), 32'({1'b1, 4'd8}));

        // Drain, then underflow
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("udf_after_drain", 32'({r_udf, r_empty}), 32'({1'b1, 1'b1}));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Wrap-around with level held within 3..5
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        popped = 0;
        for (int i = 0; i < 200 && popped < 20; i++) begin
            we = 1'($urandom);
            re = 1'($urandom);
            if (model.size() >= 5 && we && !re) we = 1'b0;
            if (model.size() <= 3 && re && !we) re = 1'b0;
            step(we, DW'($urandom), re, 1'b0, 1'b0);
        end
        check("wrap_pops_done", 32'(popped >= 20), 32'd1);

        // Simultaneous write+read at level 4, 8 and 0
        while (model.size() > 4) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0444, 1'b1, 1'b0, 1'b0);
        check("simul_l4", 32'(r_level), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0888, 1'b1, 1'b0, 1'b0);
        check("simul_l8", 32'({r_ovf, r_level}), 32'({1'b1, 4'd7}));
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h0111, 1'b1, 1'b0, 1'b0);
        check("simul_l0", 32'({r_udf, r_level}), 32'({1'b1, 4'd1}));
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // FWFT fall-through and error clear priority
        step(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        check("fwft_aa", 32'({f_valid, f_data}), 32'({1'b1, 16'h00AA}));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("clr_vs_set", 32'(r_udf), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("clr_alone", 32'(r_udf), 32'd0);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), DW'($urandom), 1'($urandom), ($urandom_range(15) == 0),
                 ($urandom_range(63) == 0));
        end

        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("reg_pending", 32'(exp0_data.size()), 32'd0);
        check("fwft_pending", 32'(exp1_data.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
